// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: requester handshake, clear command and registered RF write port
interface rf_write_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          clear_request;
  logic                          write_enable;
  logic [ADDR_WIDTH-1:0]         write_address;
  logic [DATA_WIDTH-1:0]         write_data;
  logic                          clear_busy;
  logic                          clear_done;
  modport master (
    output req_valid, req_address, req_data, clear_request,
    input  req_ready, write_enable, write_address, write_data, clear_busy, clear_done
  );
  modport slave (
    input  req_valid, req_address, req_data, clear_request,
    output req_ready, write_enable, write_address, write_data, clear_busy, clear_done
  );
endinterface

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the RF write port with a zero-fill clear sweep
module rf_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
) (
  input logic              clk,
  input logic              rst,
  rf_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic {RUN, CLEAR} state_t;
  state_t                  state, state_n;
  logic [PW-1:0]           ptr, gidx, cand;
  logic [NUM_REQ-1:0]      grant;
  logic                    found, xfer;
  logic [ADDR_WIDTH-1:0]   count, gaddr;
  logic [DATA_WIDTH-1:0]   gdata;
  // first valid requester at or after the pointer, wrapping
  always_comb begin
    grant = '0;
    gidx  = ptr;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        grant[cand] = 1'b1;
        gidx        = cand;
        found       = 1'b1;
      end
    end
  end
  always_comb begin
    gaddr = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == gidx) begin
        gaddr = bus.req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        gdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  assign xfer           = (state == RUN) && found;
  assign bus.req_ready  = (state == RUN && !rst) ? grant : '0;
  assign bus.clear_busy = (state == CLEAR);
  always_comb begin
    state_n = state;
    if (state == RUN) state_n = bus.clear_request ? CLEAR : RUN;
    else state_n = (count == '1) ? RUN : CLEAR;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RUN;
      ptr               <= '0;
      count             <= '0;
      bus.write_enable  <= 1'b0;
      bus.write_address <= '0;
      bus.write_data    <= '0;
      bus.clear_done    <= 1'b0;
    end else begin
      state          <= state_n;
      bus.clear_done <= (state == CLEAR) && (count == '1);
      if (state == CLEAR) begin
        bus.write_enable  <= 1'b1;
        bus.write_address <= count;
        bus.write_data    <= '0;
        count             <= count + 1'b1;
      end else if (xfer) begin
        bus.write_enable  <= 1'b1;
        bus.write_address <= gaddr;
        bus.write_data    <= gdata;
        ptr               <= (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
      end else begin
        bus.write_enable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: random stimulus, reference model feeds a write scoreboard
module tb_rf_write_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 1 << AW;
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          last;
  } wr_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  rf_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();
  rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  wr_t exp_q[$];
  int  passed = 0;
  int  total  = 0;
  int  m_ptr  = 0;
  int  m_sweep = 0;
  bit  mon_on = 1'b0;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else passed++;
  endtask
  // one clock of stimulus; the model predicts the grant and any write it causes
  task automatic step(logic [N-1:0] v, logic clr, logic r);
    int  g;
    wr_t w;
    @(negedge clk);
    rst = r;
    bus.req_valid = v;
    bus.clear_request = clr;
    for (int i = 0; i < N; i++) begin
      bus.req_address[i*AW +: AW] = AW'($urandom);
      bus.req_data[i*DW +: DW]    = DW'($urandom);
    end
    g = -1;
    if (m_sweep == 0 && !r)
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    #1;
    check("req_ready", 32'(bus.req_ready), (g < 0) ? 32'd0 : 32'd1 << g);
    if (!r) check("clear_busy", 32'(bus.clear_busy), 32'(m_sweep > 0));
    @(posedge clk);
    if (r) begin
      m_sweep = 0;
      m_ptr   = 0;
    end else if (m_sweep > 0) begin
      w.a = AW'(NR - m_sweep);
      w.d = '0;
      w.last = (m_sweep == 1);
      exp_q.push_back(w);
      m_sweep--;
    end else begin
      if (g >= 0) begin
        w.a = bus.req_address[g*AW +: AW];
        w.d = bus.req_data[g*DW +: DW];
        w.last = 1'b0;
        exp_q.push_back(w);
        m_ptr = (g + 1) % N;
      end
      if (clr) m_sweep = NR;
    end
  endtask
  always @(negedge clk) begin
    wr_t w;
    if (mon_on) begin
      check("write_enable", 32'(bus.write_enable), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("write_address", 32'(bus.write_address), 32'(w.a));
        check("write_data", 32'(bus.write_data), 32'(w.d));
        check("clear_done", 32'(bus.clear_done), 32'(w.last));
      end else begin
        check("clear_done_idle", 32'(bus.clear_done), 32'd0);
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.clear_request = 1'b0;
    bus.req_address = '0;
    bus.req_data = '0;
    step(2'b11, 1'b0, 1'b1);
    mon_on = 1'b1;
    step(2'b11, 1'b0, 1'b1);
    #1;
    check("reset_write_enable", 32'(bus.write_enable), 32'd0);
    check("reset_write_address", 32'(bus.write_address), 32'd0);
    check("reset_write_data", 32'(bus.write_data), 32'd0);
    check("reset_clear_done", 32'(bus.clear_done), 32'd0);
    check("reset_clear_busy", 32'(bus.clear_busy), 32'd0);
    repeat (6) step(2'b11, 1'b0, 1'b0);
    repeat (3) step(2'b10, 1'b0, 1'b0);
    step(2'b11, 1'b0, 1'b0);
    repeat (4) step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    repeat (6) step(2'b11, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    repeat (2) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b1);
    step(2'b00, 1'b1, 1'b0);
    repeat (5) step(2'b00, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0);
    step(2'b01, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0);
    repeat (4) step(2'b01, 1'b0, 1'b0);
    repeat (3000) step(N'($urandom), ($urandom % 12) == 0, ($urandom % 150) == 0);
    repeat (3) step(2'b00, 1'b0, 1'b0);
    repeat (NR + 2) step(2'b00, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
